// File: rtl/poly1305_carry_reduce.sv
// poly1305_carry_reduce
// Carry-propagates the five 64-bit column sums from the Poly1305 multiply
// stage into 32-bit limbs. Bits at weight 2^130 and above are folded back in
// as 5*c, because 2^130 = 5 (mod 2^130-5). A single 67-bit adder is shared
// and handles one limb per cycle.
//
// Ports:
//   clk, reset_n    clock; synchronous active-low reset
//   start           one-cycle request; s0..s4 are sampled on the same edge
//   s0..s4          column sums at weights 2^0, 2^32, 2^64, 2^96 and 2^128
//   ready           result valid; cleared on accept, set on completion
//   h0..h4          reduced limbs at weight 2^(32i); registered
//
// Optional feature macro: POLY1305_CARRY_REDUCE_FINAL_EN
//   When defined, a FINAL state adds one cycle. It performs the conditional
//   subtraction of 2^130-5, which gives a canonical result (latency 11).
//   When undefined, the result is only partially reduced (latency 10).

module poly1305_carry_reduce (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] s0,
  input  logic [63:0] s1,
  input  logic [63:0] s2,
  input  logic [63:0] s3,
  input  logic [63:0] s4,
  output logic        ready,
  output logic [31:0] h0,
  output logic [31:0] h1,
  output logic [31:0] h2,
  output logic [31:0] h3,
  output logic [31:0] h4
);

  localparam int unsigned LIMB_W  = 32;
  localparam int unsigned SUM_W   = 64;
  localparam int unsigned ADD_W   = 67;
  localparam int unsigned CARRY_W = 35;
  localparam int unsigned C_W     = 62;
  localparam int unsigned NLIMB   = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CARRY = 3'd1,
    FOLD  = 3'd2,
    PROP  = 3'd3,
    FINAL = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [SUM_W-1:0]    s_q [NLIMB];
  logic [LIMB_W-1:0]   h_q [NLIMB];
  logic [CARRY_W-1:0]  carry_q;
  logic [C_W-1:0]      c_q;
  logic                ready_q;

  logic [SUM_W-1:0]    s_sel;
  logic [LIMB_W-1:0]   h_sel;
  logic [ADD_W-1:0]    add_a, add_b, sum;

`ifdef POLY1305_CARRY_REDUCE_FINAL_EN
  logic [160:0]        g;
`endif

  // Select the operand limb addressed by idx
  always_comb begin
    s_sel = '0;
    h_sel = '0;
    for (int i = 0; i < int'(NLIMB); i++) begin
      if (idx_q == 3'(i)) begin
        s_sel = s_q[i];
        h_sel = h_q[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and shared-adder operand selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    add_a   = '0;
    add_b   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CARRY;
          idx_d   = 3'd0;
        end
      end
      CARRY: begin
        add_a = ADD_W'(s_sel);
        add_b = ADD_W'(carry_q);
        if (idx_q == 3'd4) begin
          state_d = FOLD;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      FOLD: begin
        // 5*c as (c<<2)+c; at most 65 bits
        add_a   = ADD_W'(h_q[0]);
        add_b   = ADD_W'({c_q, 2'b00}) + ADD_W'(c_q);
        state_d = PROP;
        idx_d   = 3'd1;
      end
      PROP: begin
        add_a = ADD_W'(h_sel);
        add_b = ADD_W'(carry_q);
        if (idx_q == 3'd4) begin
`ifdef POLY1305_CARRY_REDUCE_FINAL_EN
          state_d = FINAL;
`else
          state_d = IDLE;
`endif
          idx_d = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef POLY1305_CARRY_REDUCE_FINAL_EN
      FINAL: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign sum = add_a + add_b;

`ifdef POLY1305_CARRY_REDUCE_FINAL_EN
  // G = H + 5; a set bit at 2^130 or above means H >= 2^130-5
  always_comb begin
    g = {1'b0, h_q[4], h_q[3], h_q[2], h_q[1], h_q[0]} + 161'd5;
  end
`endif

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NLIMB); i++) begin
        s_q[i] <= '0;
        h_q[i] <= '0;
      end
      carry_q <= '0;
      c_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q[0]  <= s0;
            s_q[1]  <= s1;
            s_q[2]  <= s2;
            s_q[3]  <= s3;
            s_q[4]  <= s4;
            ready_q <= 1'b0;
            carry_q <= '0;
          end
        end
        CARRY: begin
          if (idx_q == 3'd4) begin
            // Keep bits 129:128 in h4; everything above is folded later
            h_q[4] <= {30'b0, sum[1:0]};
            c_q    <= sum[63:2];
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (idx_q == 3'(i)) h_q[i] <= sum[31:0];
            end
            carry_q <= CARRY_W'(sum[63:32]);
          end
        end
        FOLD: begin
          h_q[0]  <= sum[31:0];
          carry_q <= sum[66:32];
        end
        PROP: begin
          for (int i = 1; i < int'(NLIMB); i++) begin
            if (idx_q == 3'(i)) h_q[i] <= sum[31:0];
          end
          carry_q <= sum[66:32];
`ifndef POLY1305_CARRY_REDUCE_FINAL_EN
          if (idx_q == 3'd4) ready_q <= 1'b1;
`endif
        end
`ifdef POLY1305_CARRY_REDUCE_FINAL_EN
        FINAL: begin
          if (|g[160:130]) begin
            h_q[0] <= g[31:0];
            h_q[1] <= g[63:32];
            h_q[2] <= g[95:64];
            h_q[3] <= g[127:96];
            h_q[4] <= {30'b0, g[129:128]};
          end
          ready_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign ready = ready_q;
  assign h0    = h_q[0];
  assign h1    = h_q[1];
  assign h2    = h_q[2];
  assign h3    = h_q[3];
  assign h4    = h_q[4];

endmodule
